// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions.
// Holds the segment decode table, the anode position map, the blank code and
// the capture FSM state encoding, so the capture block and a display driver
// agree on one source of truth.
// No ports (package).
package sevenseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 4;
  localparam int NUM_CODES  = 10;

  // Active-low cathode patterns, bit7 = DP, bits6..0 = a..g; index = digit.
  localparam logic [7:0] SEG_CODE [NUM_CODES] = '{
    8'b1000_0001, 8'b1100_1111, 8'b1001_0010, 8'b1000_0110, 8'b1100_1100,
    8'b1010_0100, 8'b1010_0000, 8'b1000_1111, 8'b1000_0000, 8'b1000_0100
  };

  localparam logic [7:0] SEG_BLANK   = 8'hFF;
  localparam logic [3:0] BLANK_VALUE = 4'hF;

  // Active-low one-cold anode select per LED position.
  localparam logic [3:0] ANODE_SEL [NUM_DIGITS] = '{
    4'b0111, 4'b1011, 4'b1101, 4'b1110
  };

  // Idle (nothing driven) bus levels.
  localparam logic [3:0] ANODE_IDLE   = 4'hF;
  localparam logic [7:0] CATHODE_IDLE = 8'hFF;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } pos_t;

  // Map an anode value to its LED position; valid=0 means "no digit".
  function automatic pos_t anode_lookup(input logic [3:0] anode);
    pos_t p;
    p.valid = 1'b0;
    p.idx   = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (anode == ANODE_SEL[i]) begin
        p.valid = 1'b1;
        p.idx   = 2'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/sevenseg_capture_if.sv
// Bus bundle between a multiplexed seven-segment display and the capture block.
// master: drives anode_in/cathode_in, observes the decoded results.
// slave : the capture block (samples the display bus, drives the results).
//   anode_in[3:0]    active-low one-cold digit select
//   cathode_in[7:0]  active-low segments, bit7 = DP
//   LED0..LED3[3:0]  last decoded value per position
//   blank[3:0]       position last showed all segments off
//   captured[3:0]    position written since the last frame_done
//   frame_done       one-clock pulse when all four positions were captured
//   decode_err       one-clock pulse on a stable unrecognised pattern
interface sevenseg_capture_if;
  logic [3:0] anode_in;
  logic [7:0] cathode_in;
  logic [3:0] LED0;
  logic [3:0] LED1;
  logic [3:0] LED2;
  logic [3:0] LED3;
  logic [3:0] blank;
  logic [3:0] captured;
  logic       frame_done;
  logic       decode_err;

  modport master (
    output anode_in, cathode_in,
    input  LED0, LED1, LED2, LED3, blank, captured, frame_done, decode_err
  );

  modport slave (
    input  anode_in, cathode_in,
    output LED0, LED1, LED2, LED3, blank, captured, frame_done, decode_err
  );
endinterface

// File: rtl/sevenseg_decode.sv
// Combinational cathode-pattern lookup.
//   pattern[7:0]  active-low segment pattern
//   value[3:0]    decoded digit, BLANK_VALUE for the all-off pattern
//   is_blank      pattern is all segments off
//   hit           pattern is in the table (digits or blank)
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [7:0] pattern,
  output logic [3:0] value,
  output logic       is_blank,
  output logic       hit
);

  logic [NUM_CODES-1:0] match;

  generate
    for (genvar gi = 0; gi < NUM_CODES; gi++) begin : g_match
      assign match[gi] = (pattern == SEG_CODE[gi]);
    end
  endgenerate

  // Table entries are distinct, so at most one match bit is set.
  always_comb begin
    value    = BLANK_VALUE;
    is_blank = 1'b0;
    hit      = 1'b0;
    if (pattern == SEG_BLANK) begin
      is_blank = 1'b1;
      hit      = 1'b1;
    end
    for (int i = 0; i < NUM_CODES; i++) begin
      if (match[i]) begin
        value = 4'(i);
        hit   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Recovers the four displayed digits from a multiplexed seven-segment bus.
// The bus is sampled once, then a position must hold anode and cathode steady
// for SETTLE_CYCLES clocks before its pattern is decoded and stored.
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous active-low reset
//   bus  : sevenseg_capture_if.slave (display bus in, decoded results out)
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16
) (
  input logic               clk,
  input logic               rst,
  sevenseg_capture_if.slave bus
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  logic [3:0] anode_s_reg;
  logic [7:0] cathode_s_reg;
  logic [3:0] anode_p_reg;
  logic [7:0] cathode_p_reg;
  state_t     state_reg;
  logic [7:0] cnt_reg;
  logic [3:0] cap_anode_reg;
  logic [3:0] led_reg [NUM_DIGITS];
  logic [3:0] blank_reg;
  logic [3:0] captured_reg;
  logic       frame_done_reg;
  logic       decode_err_reg;

  pos_t       pos;
  logic       stable;
  logic       capture_fire;
  logic [3:0] capture_set;
  logic [3:0] dec_value;
  logic       dec_blank;
  logic       dec_hit;

  sevenseg_decode u_decode (
    .pattern  (cathode_s_reg),
    .value    (dec_value),
    .is_blank (dec_blank),
    .hit      (dec_hit)
  );

  assign pos    = anode_lookup(anode_s_reg);
  assign stable = (anode_s_reg == anode_p_reg) && (cathode_s_reg == cathode_p_reg);

  // The counter value SETTLE_LAST means the window is complete; this edge captures.
  assign capture_fire = (state_reg == ST_SETTLE) && pos.valid && stable &&
                        (cnt_reg >= SETTLE_LAST);
  assign capture_set  = (capture_fire && dec_hit) ? (4'b0001 << pos.idx) : 4'b0000;

  always_ff @(posedge clk) begin
    if (!rst) begin
      anode_s_reg    <= ANODE_IDLE;
      cathode_s_reg  <= CATHODE_IDLE;
      anode_p_reg    <= ANODE_IDLE;
      cathode_p_reg  <= CATHODE_IDLE;
      state_reg      <= ST_IDLE;
      cnt_reg        <= 8'd0;
      cap_anode_reg  <= ANODE_IDLE;
      for (int i = 0; i < NUM_DIGITS; i++) led_reg[i] <= 4'h0;
      blank_reg      <= 4'b0000;
      captured_reg   <= 4'b0000;
      frame_done_reg <= 1'b0;
      decode_err_reg <= 1'b0;
    end else begin
      anode_s_reg    <= bus.anode_in;
      cathode_s_reg  <= bus.cathode_in;
      anode_p_reg    <= anode_s_reg;
      cathode_p_reg  <= cathode_s_reg;
      frame_done_reg <= 1'b0;
      decode_err_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (pos.valid) begin
            state_reg <= ST_SETTLE;
            cnt_reg   <= 8'd0;
          end
        end
        ST_SETTLE: begin
          if (!pos.valid) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 8'd0;
          end else if (!stable) begin
            cnt_reg <= 8'd0;
          end else if (capture_fire) begin
            state_reg     <= ST_HOLD;
            cnt_reg       <= 8'd0;
            cap_anode_reg <= anode_s_reg;
            if (dec_hit) begin
              led_reg[pos.idx]   <= dec_value;
              blank_reg[pos.idx] <= dec_blank;
            end else begin
              decode_err_reg <= 1'b1;
            end
          end else if (cnt_reg != 8'hFF) begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        ST_HOLD: begin
          // Only an anode change releases HOLD; cathode changes are ignored.
          if (anode_s_reg != cap_anode_reg) begin
            state_reg <= pos.valid ? ST_SETTLE : ST_IDLE;
            cnt_reg   <= 8'd0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= 8'd0;
        end
      endcase

      // A full set is reported one edge later; a capture landing on that
      // same edge survives the clear.
      if (captured_reg == 4'b1111) begin
        frame_done_reg <= 1'b1;
        captured_reg   <= capture_set;
      end else begin
        captured_reg <= captured_reg | capture_set;
      end
    end
  end

  assign bus.LED0       = led_reg[0];
  assign bus.LED1       = led_reg[1];
  assign bus.LED2       = led_reg[2];
  assign bus.LED3       = led_reg[3];
  assign bus.blank      = blank_reg;
  assign bus.captured   = captured_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.decode_err = decode_err_reg;

endmodule

// File: doc/sevenseg_capture.md
SEVENSEG_CAPTURE -- requirements
Module: sevenseg_capture

Interface
REQ-001 The module SHALL have parameter SETTLE_CYCLES, default 16, meaning clocks that anode and cathode must be stable before a capture (legal 1..255).
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-low (rst==0 resets).
REQ-004 anode_in  input  4  multiplexed anode bus, active-low, one-cold when driving a digit.
REQ-005 cathode_in  input  8  segment bus, active-low, bit7=DP, bits6..0=a..g.
REQ-006 LED0, LED1, LED2, LED3  output  4 each  last decoded value per digit position.
REQ-007 blank  output  4  bit i set when position i last showed all-segments-off.
REQ-008 captured  output  4  bit i set when position i was written since the last frame_done.
REQ-009 frame_done  output  1  one-clock pulse when all four positions have been captured.
REQ-010 decode_err  output  1  one-clock pulse on a stable, unrecognised cathode pattern.

Function
REQ-011 Position map SHALL be: anode_in 4'b0111->LED0, 4'b1011->LED1, 4'b1101->LED2, 4'b1110->LED3; any other anode value is "no digit".
REQ-012 Decode table (cathode_in -> value) SHALL be: 10000001->0, 11001111->1, 10010010->2, 10000110->3, 11001100->4, 10100100->5, 10100000->6, 10001111->7, 10000000->8, 10000100->9, 11111111->blank (value 4'hF, blank bit set).
REQ-013 anode_in and cathode_in SHALL be registered once (sample stage) before any comparison; all latencies count from that registered copy.
REQ-014 FSM states SHALL be IDLE, SETTLE, HOLD.
REQ-015 IDLE: on a valid one-cold sampled anode -> SETTLE with stability counter cleared; otherwise remain.
REQ-016 SETTLE: counter increments each clock while sampled anode and cathode equal previous clock's; any change clears the counter; anode becoming "no digit" -> IDLE.
REQ-017 SETTLE: when counter reaches SETTLE_CYCLES-1, the next edge SHALL perform the capture and enter HOLD.
REQ-018 Capture of a table hit SHALL write LEDi, set/clear blank[i], set captured[i], all in the same edge.
REQ-019 Capture of a non-table pattern SHALL pulse decode_err, leave LEDi/blank[i]/captured[i] unchanged.
REQ-020 HOLD: stay until sampled anode differs from the captured anode; then -> SETTLE if new anode valid, else IDLE; cathode changes in HOLD are ignored.
REQ-021 When captured becomes 4'b1111 the next edge SHALL pulse frame_done and clear captured to 4'b0000; a capture on that same edge SHALL set its bit after the clear.
REQ-022 Recapturing an already-set position SHALL overwrite LEDi and not affect frame_done timing.
REQ-023 Stability counter SHALL be 8 bits and saturate, never wrap.

Reset
REQ-024 While rst==0: state=IDLE, counter=0, LED0..LED3=4'h0, blank=4'b0000, captured=4'b0000, frame_done=0, decode_err=0, sample registers=8'hFF/4'hF.
REQ-025 Reset asserted mid-SETTLE or mid-HOLD SHALL abandon the capture with no partial writes; first capture after release needs a full SETTLE_CYCLES window.

Structure
REQ-026 The decode table, position-map anode constants, blank code 4'hF and FSM state encodings SHALL live in shared package sevenseg_pkg, also usable by the display driver.
REQ-027 The pattern-to-value lookup SHALL be a combinational sub-module sevenseg_decode (input 8-bit pattern, outputs value[3:0], is_blank, hit).

Verification
REQ-028 anode 4'b0111, cathode 10010010 held 16 clocks -> LED0=2, captured=4'b0001, no decode_err.
REQ-029 Cycle anodes 0111,1011,1101,1110 with digits 1,9,blank,7, each held 20 clocks -> LED0..3=1,9,F,7, blank=4'b0100, one frame_done pulse, captured returns 4'b0000.
REQ-030 anode 1011, cathode toggling every 10 clocks for 60 clocks then stable -> no capture until 16 stable clocks after last toggle.
REQ-031 anode 1101, cathode 11111110 held 16 clocks -> single decode_err pulse, LED2 and captured unchanged.
REQ-032 anode 1111 or 0011 for 100 clocks -> state stays IDLE, no outputs change.
REQ-033 rst=0 at clock 10 of a 16-clock SETTLE on LED3 -> all outputs at reset values; after release, capture only after 16 further stable clocks.
